// File: rtl/uart_rx_if.sv
// uart_rx_if: CPU-side handshake between the UART receiver and its consumer.
// The receiver (master) presents the byte, irr and status flags; the CPU
// (slave) answers with a one-cycle ack strobe.
interface uart_rx_if;
    logic [7:0] rx_data;
    logic       irr;
    logic       ack;
    logic       overrun;
    logic       frame_err;

    modport master (output rx_data, irr, overrun, frame_err, input ack);
    modport slave  (input rx_data, irr, overrun, frame_err, output ack);
endinterface

// File: rtl/uart_rx.sv
// uart_rx: oversampling 8N1 serial receiver feeding the CPU irr/ack/rx_data port.
// Optional feature macro: UART_RX_FIFO_EN replaces the single holding register
// with a 4-entry FIFO (drop-new on overflow). Without it, a new byte overwrites
// an unconsumed one and flags overrun.
module uart_rx #(
    parameter int unsigned CLK_FREQ = 12_000_000,
    parameter int unsigned BAUD     = 1_000_000
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      rx,
    uart_rx_if.master bus
);
    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_DATA      = 3'd2;
    localparam logic [2:0] ST_STOP      = 3'd3;
    localparam logic [2:0] ST_WAIT_HIGH = 3'd4;

    generate
        if (CLKS_PER_BIT < 4) begin : g_bad_baud
            $error("uart_rx: CLK_FREQ/BAUD must be at least 4");
        end
    endgenerate

    logic [2:0]       sync_q, sync_d;
    logic             rx_s, rx_prev;
    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             byte_done_q, byte_done_d;
    logic             frame_bad_q, frame_bad_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q, overrun_d;

    assign rx_s    = sync_q[1];
    assign rx_prev = sync_q[2];

    // Two-stage synchronizer plus one extra stage for falling-edge detection.
    always_comb begin
        sync_d = {sync_q[1:0], rx};
    end

    // Receive FSM: the mid-start sample lands HALF clocks after the edge is seen,
    // then each data bit and the stop bit are sampled one full bit period apart.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        byte_done_d = 1'b0;
        frame_bad_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rx_prev && !rx_s) begin
                    state_d = ST_START;
                    cnt_d   = '0;
                end
            end
            ST_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = rx_s ? ST_IDLE : ST_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d     = '0;
                    shift_d   = {rx_s, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        byte_done_d = 1'b1;
                        state_d     = ST_IDLE;
                    end else begin
                        frame_bad_d = 1'b1;
                        state_d     = ST_WAIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WAIT_HIGH: begin
                if (rx_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Frame error is reported one cycle after the stop sample, aligned with delivery.
    always_comb begin
        frame_err_d = frame_bad_q;
    end

    // Receiver state registers; reset aborts any frame in progress.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q      <= 3'b111;
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            byte_done_q <= 1'b0;
            frame_bad_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            byte_done_q <= byte_done_d;
            frame_bad_q <= frame_bad_d;
            frame_err_q <= frame_err_d;
        end
    end

`ifdef UART_RX_FIFO_EN
    logic [7:0] mem_q [4];
    logic [7:0] mem_d [4];
    logic [1:0] wr_ptr_q, wr_ptr_d;
    logic [1:0] rd_ptr_q, rd_ptr_d;
    logic [2:0] count_q, count_d;
    logic       pop, push, full;

    // FIFO bookkeeping: a pop frees a slot in the same cycle, so push-while-full
    // with a simultaneous pop is accepted; otherwise the new byte is dropped.
    always_comb begin
        full      = (count_q == 3'd4);
        pop       = bus.ack && (count_q != 3'd0);
        push      = byte_done_q && (!full || pop);
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        overrun_d = overrun_q;
        if (push) begin
            mem_d[wr_ptr_q] = shift_q;
            wr_ptr_d        = wr_ptr_q + 2'd1;
        end
        if (pop) begin
            rd_ptr_d  = rd_ptr_q + 2'd1;
            overrun_d = 1'b0;
        end
        if (byte_done_q && full && !pop) begin
            overrun_d = 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase
    end

    // FIFO storage and pointer registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
        end
    end

    assign bus.rx_data = mem_q[rd_ptr_q];
    assign bus.irr     = (count_q != 3'd0);
`else
    logic [7:0] hold_q, hold_d;
    logic       irr_q, irr_d;
    logic       ack_ok;

    // Single holding register: ack consumes, a new byte always loads, and it
    // only counts as an overrun when the pending byte was not consumed this cycle.
    always_comb begin
        ack_ok    = bus.ack && irr_q;
        hold_d    = hold_q;
        irr_d     = irr_q;
        overrun_d = overrun_q;
        if (ack_ok) begin
            irr_d     = 1'b0;
            overrun_d = 1'b0;
        end
        if (byte_done_q) begin
            hold_d = shift_q;
            irr_d  = 1'b1;
            if (irr_q && !bus.ack) begin
                overrun_d = 1'b1;
            end
        end
    end

    // Holding register and status flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_q    <= '0;
            irr_q     <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            irr_q     <= irr_d;
            overrun_q <= overrun_d;
        end
    end

    assign bus.rx_data = hold_q;
    assign bus.irr     = irr_q;
`endif

    assign bus.overrun   = overrun_q;
    assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed self-checking bench for uart_rx at 12 clocks per bit.
// Inputs change on the falling clock edge and outputs are sampled there too.
module tb_uart_rx;
    localparam int CPB = 12;

    logic clk;
    logic reset;
    logic rx;
    int   checks   = 0;
    int   errors   = 0;
    int   fe_count = 0;

    uart_rx_if bus_if ();

    uart_rx #(
        .CLK_FREQ(12_000_000),
        .BAUD    (1_000_000)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .rx   (rx),
        .bus  (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count every cycle in which frame_err is seen high.
    always @(negedge clk) begin
        if (bus_if.frame_err === 1'b1) fe_count <= fe_count + 1;
    end

    // Drive one frame starting at the current falling edge; returns with the line high.
    task automatic send_frame(input logic [7:0] data, input logic stop_val, input int stop_bits);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_val;
        repeat (CPB * stop_bits) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic pulse_ack();
        bus_if.ack = 1'b1;
        @(negedge clk);
        bus_if.ack = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus_if.irr !== 1'b0) begin errors++; $display("[TB] FAIL reset_irr: got %b expected 0", bus_if.irr); end
        checks++; if (bus_if.rx_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_rx_data: got %h expected 00", bus_if.rx_data); end
        checks++; if (bus_if.overrun !== 1'b0) begin errors++; $display("[TB] FAIL reset_overrun: got %b expected 0", bus_if.overrun); end
        checks++; if (bus_if.frame_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_frame_err: got %b expected 0", bus_if.frame_err); end
        reset = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_basic();
        fork
            send_frame(8'hA5, 1'b1, 1);
            begin
                repeat (117) @(negedge clk);
                checks++; if (bus_if.irr !== 1'b0) begin errors++; $display("[TB] FAIL basic_irr_early: got %b expected 0", bus_if.irr); end
                @(negedge clk);
                checks++; if (bus_if.irr !== 1'b1) begin errors++; $display("[TB] FAIL basic_irr_rise: got %b expected 1", bus_if.irr); end
                checks++; if (bus_if.rx_data !== 8'hA5) begin errors++; $display("[TB] FAIL basic_rx_data: got %h expected a5", bus_if.rx_data); end
            end
        join
        pulse_ack();
        checks++; if (bus_if.irr !== 1'b0) begin errors++; $display("[TB] FAIL basic_ack_irr: got %b expected 0", bus_if.irr); end
        checks++; if (bus_if.overrun !== 1'b0) begin errors++; $display("[TB] FAIL basic_ack_overrun: got %b expected 0", bus_if.overrun); end
        pulse_ack();
        checks++; if (bus_if.irr !== 1'b0) begin errors++; $display("[TB] FAIL basic_stray_ack: got %b expected 0", bus_if.irr); end
    endtask

    task automatic test_false_start();
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (30) @(negedge clk);
        checks++; if (bus_if.irr !== 1'b0) begin errors++; $display("[TB] FAIL false_start_irr: got %b expected 0", bus_if.irr); end
        send_frame(8'h3C, 1'b1, 1);
        checks++; if (bus_if.irr !== 1'b1) begin errors++; $display("[TB] FAIL false_start_next_irr: got %b expected 1", bus_if.irr); end
        checks++; if (bus_if.rx_data !== 8'h3C) begin errors++; $display("[TB] FAIL false_start_next_data: got %h expected 3c", bus_if.rx_data); end
        pulse_ack();
    endtask

    task automatic test_frame_error();
        int fe_start;
        fe_start = fe_count;
        fork
            send_frame(8'h3C, 1'b0, 2);
            begin
                repeat (117) @(negedge clk);
                checks++; if (bus_if.frame_err !== 1'b0) begin errors++; $display("[TB] FAIL ferr_early: got %b expected 0", bus_if.frame_err); end
                @(negedge clk);
                checks++; if (bus_if.frame_err !== 1'b1) begin errors++; $display("[TB] FAIL ferr_pulse: got %b expected 1", bus_if.frame_err); end
                @(negedge clk);
                checks++; if (bus_if.frame_err !== 1'b0) begin errors++; $display("[TB] FAIL ferr_width: got %b expected 0", bus_if.frame_err); end
            end
        join
        checks++; if (bus_if.irr !== 1'b0) begin errors++; $display("[TB] FAIL ferr_irr: got %b expected 0", bus_if.irr); end
        checks++; if (fe_count - fe_start !== 1) begin errors++; $display("[TB] FAIL ferr_count: got %0d expected 1", fe_count - fe_start); end
        repeat (10) @(negedge clk);
        send_frame(8'h55, 1'b1, 1);
        checks++; if (bus_if.rx_data !== 8'h55) begin errors++; $display("[TB] FAIL ferr_recover_data: got %h expected 55", bus_if.rx_data); end
        checks++; if (bus_if.irr !== 1'b1) begin errors++; $display("[TB] FAIL ferr_recover_irr: got %b expected 1", bus_if.irr); end
        pulse_ack();
    endtask

    task automatic test_overrun();
`ifdef UART_RX_FIFO_EN
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1);
        checks++; if (bus_if.overrun !== 1'b1) begin errors++; $display("[TB] FAIL fifo_overrun: got %b expected 1", bus_if.overrun); end
        for (int i = 1; i <= 4; i++) begin
            checks++; if (bus_if.rx_data !== 8'(i)) begin errors++; $display("[TB] FAIL fifo_head: got %h expected %h", bus_if.rx_data, 8'(i)); end
            pulse_ack();
        end
        checks++; if (bus_if.irr !== 1'b0) begin errors++; $display("[TB] FAIL fifo_empty_irr: got %b expected 0", bus_if.irr); end
        checks++; if (bus_if.overrun !== 1'b0) begin errors++; $display("[TB] FAIL fifo_overrun_clear: got %b expected 0", bus_if.overrun); end
`else
        send_frame(8'h11, 1'b1, 1);
        send_frame(8'h22, 1'b1, 1);
        checks++; if (bus_if.rx_data !== 8'h22) begin errors++; $display("[TB] FAIL ovr_data: got %h expected 22", bus_if.rx_data); end
        checks++; if (bus_if.overrun !== 1'b1) begin errors++; $display("[TB] FAIL ovr_flag: got %b expected 1", bus_if.overrun); end
        pulse_ack();
        checks++; if (bus_if.irr !== 1'b0) begin errors++; $display("[TB] FAIL ovr_ack_irr: got %b expected 0", bus_if.irr); end
        checks++; if (bus_if.overrun !== 1'b0) begin errors++; $display("[TB] FAIL ovr_ack_clear: got %b expected 0", bus_if.overrun); end
`endif
    endtask

    task automatic test_ack_collision();
        send_frame(8'h11, 1'b1, 1);
        checks++; if (bus_if.rx_data !== 8'h11) begin errors++; $display("[TB] FAIL coll_first: got %h expected 11", bus_if.rx_data); end
        fork
            send_frame(8'h22, 1'b1, 1);
            begin
                repeat (117) @(negedge clk);
                pulse_ack();
                checks++; if (bus_if.irr !== 1'b1) begin errors++; $display("[TB] FAIL coll_irr: got %b expected 1", bus_if.irr); end
                checks++; if (bus_if.rx_data !== 8'h22) begin errors++; $display("[TB] FAIL coll_data: got %h expected 22", bus_if.rx_data); end
                checks++; if (bus_if.overrun !== 1'b0) begin errors++; $display("[TB] FAIL coll_overrun: got %b expected 0", bus_if.overrun); end
            end
        join
        pulse_ack();
        checks++; if (bus_if.irr !== 1'b0) begin errors++; $display("[TB] FAIL coll_drain: got %b expected 0", bus_if.irr); end
    endtask

    task automatic test_reset_midframe();
        int fe_start;
        send_frame(8'h5A, 1'b1, 1);
        checks++; if (bus_if.irr !== 1'b1) begin errors++; $display("[TB] FAIL rst_pending: got %b expected 1", bus_if.irr); end
        fe_start = fe_count;
        fork
            send_frame(8'hF0, 1'b1, 1);
            begin
                repeat (64) @(negedge clk);
                reset = 1'b0;
                @(negedge clk);
                checks++; if (bus_if.irr !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_irr: got %b expected 0", bus_if.irr); end
                checks++; if (bus_if.rx_data !== 8'h00) begin errors++; $display("[TB] FAIL rst_mid_data: got %h expected 00", bus_if.rx_data); end
                checks++; if (bus_if.overrun !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_overrun: got %b expected 0", bus_if.overrun); end
                repeat (2) @(negedge clk);
                reset = 1'b1;
            end
        join
        repeat (20) @(negedge clk);
        checks++; if (bus_if.irr !== 1'b0) begin errors++; $display("[TB] FAIL rst_spurious: got %b expected 0", bus_if.irr); end
        send_frame(8'h0F, 1'b1, 1);
        checks++; if (bus_if.irr !== 1'b1) begin errors++; $display("[TB] FAIL rst_next_irr: got %b expected 1", bus_if.irr); end
        checks++; if (bus_if.rx_data !== 8'h0F) begin errors++; $display("[TB] FAIL rst_next_data: got %h expected 0f", bus_if.rx_data); end
        checks++; if (fe_count - fe_start !== 0) begin errors++; $display("[TB] FAIL rst_frame_err: got %0d expected 0", fe_count - fe_start); end
        pulse_ack();
    endtask

    initial begin
        rx         = 1'b1;
        bus_if.ack = 1'b0;
        reset      = 1'b0;
        test_reset();
        test_basic();
        test_false_start();
        test_frame_error();
        test_overrun();
        test_ack_collision();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver that sits directly upstream of the CPU's `irr`/`ack`/`rx_data` inputs. It oversamples an asynchronous 8N1 line and assembles bytes. It presents each byte on `rx_data` and raises `irr` until the CPU acknowledges it. Framing and overrun errors are flagged so software can detect a bad link.

## Interface
- `CLK_FREQ`, 12_000_000: system clock frequency in Hz.
- `BAUD`, 1_000_000: line rate in bit/s. `CLKS_PER_BIT = CLK_FREQ / BAUD` uses integer division and must be ≥ 4 (elaboration-time assertion).
- `clk`  input  1  system clock; all state changes on its rising edge.
- `reset`  input  1  asynchronous, active-low (0 = reset asserted; release is synchronous to `clk`).
- `rx`  input  1  serial line, idle high; asynchronous to `clk`.
- `rx_data`  output  8  received byte, valid while `irr`=1.
- `irr`  output  1  byte available; level signal, held until consumed.
- `ack`  input  1  one-cycle consume strobe from CPU; ignored while `irr`=0.
- `overrun`  output  1  sticky: a byte was lost; cleared by the next accepted `ack`.
- `frame_err`  output  1  one-cycle pulse: stop bit sampled low.

## Operation
- `rx` passes through a 2-FF synchronizer (`rx_s`), reset to 1. All decisions use `rx_s`.
- FSM states:
  - IDLE: a falling edge of `rx_s` starts the bit counter at 0 and moves to START.
  - START: at count `CLKS_PER_BIT/2`, if `rx_s`=1 it is a false start and the FSM returns to IDLE. Otherwise the counter restarts and the FSM moves to DATA.
  - DATA: samples `rx_s` every `CLKS_PER_BIT` clocks, 8 times, LSB first, into a shift register.
  - STOP: samples `rx_s` after `CLKS_PER_BIT` clocks. If 1, the byte is delivered and the FSM returns to IDLE. If 0, `frame_err` pulses, the byte is discarded and the FSM moves to WAIT_HIGH.
  - WAIT_HIGH: stays until `rx_s`=1, then goes to IDLE (break tolerance).
- Delivery without FIFO:
  - Single holding register. The byte loads `rx_data` and sets `irr`.
  - If `irr` is already 1 and no `ack` arrives in the same cycle, the new byte overwrites `rx_data` and `overrun` is set.
- `ack` with `irr`=1 clears `irr` and `overrun`. If delivery and `ack` coincide, the old byte is consumed, the new byte loads, `irr` stays 1 and no overrun is raised.
- Reset mid-frame aborts the frame. The FSM returns to IDLE and all outputs take their reset values.
- Reset values: `rx_data`=0x00, `irr`=0, `overrun`=0, `frame_err`=0, FSM=IDLE.

## Timing
- Synchronizer latency: 2 clocks from a `rx` edge to `rx_s`.
- Mid-start sample occurs `CLKS_PER_BIT/2` clocks after the detected falling edge of `rx_s`.
- Data bit n (n=0..7) is sampled `(n+1)·CLKS_PER_BIT` clocks after the mid-start sample. The stop bit is sampled at `9·CLKS_PER_BIT`.
- `irr` and `rx_data` update on the clock edge following the stop sample (1-cycle latency). `frame_err` is high for exactly that cycle.
- `ack` sampled at edge k drops `irr` at edge k (visible after k). A back-to-back `ack` at k+1 is ignored if `irr`=0.
- The receiver can accept a new start edge in the cycle after a valid stop sample. Continuous back-to-back frames are supported.

## Configuration
- `UART_RX_FIFO_EN` defined:
  - The holding register is replaced by a 4-entry FIFO (2-bit pointers plus a 3-bit count).
  - `rx_data` shows the head entry and `irr` = FIFO not empty.
  - `ack` pops one entry. A byte arriving when the FIFO is full is dropped, the contents are unchanged, and `overrun` is set.
  - Push and pop in the same cycle when full is accepted: the count is unchanged and there is no overrun.
- Not defined: single holding register with overwrite-on-overrun, as described under Operation.

## Test plan
All tests use `CLK_FREQ`=12_000_000 and `BAUD`=1_000_000, giving 12 clocks per bit.
- Send 0xA5 (8N1) → `irr`=1 one clock after the stop sample, `rx_data`=0xA5; pulse `ack` → `irr`=0 next cycle, `overrun`=0.
- Drive `rx` low for 3 clocks, then high → no `irr`, FSM back in IDLE; then send 0x3C → `rx_data`=0x3C.
- Send 0x3C with the stop bit held low for 2 bit times → `frame_err` high exactly 1 cycle, `irr` stays 0; then line high and send 0x55 → `rx_data`=0x55.
- Without FIFO: send 0x11 and 0x22 with no `ack` → `rx_data`=0x22, `overrun`=1; `ack` → `irr`=0, `overrun`=0. With FIFO: send 0x01–0x05 with no `ack` → `overrun`=1; four `ack`s read 0x01, 0x02, 0x03, 0x04, then `irr`=0.
- Time `ack` to the same cycle as the 0x22 delivery while 0x11 is pending → `irr` stays 1, `rx_data`=0x22, `overrun`=0.
- Assert `reset`=0 during data bit 4 of 0xF0, release, then send 0x0F → all outputs zero during reset; only 0x0F is delivered, with no spurious byte or `frame_err`.
